// File: rtl/enc_pkg.sv
// Shared types and size helpers for the encoding sequencer.
package enc_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_ACK = 2'd2,
    DONE     = 2'd3
  } enc_seq_state_t;

  // Hypervector rows, one per projection word group
  function automatic int unsigned calc_rows(input int unsigned dhv, input int unsigned width);
    return dhv / width;
  endfunction

  // Feature words per row
  function automatic int unsigned calc_cols(input int unsigned div, input int unsigned width);
    return div / width;
  endfunction

  // Beats per row, rounding up so a partial final beat is still issued
  function automatic int unsigned calc_beats(input int unsigned cols, input int unsigned lanes);
    return (cols + lanes - 1) / lanes;
  endfunction

endpackage

// File: rtl/enc_lane_addr_gen.sv
// Per-lane projection/feature address generator for one (row, beat) pair.
module enc_lane_addr_gen #(
  parameter int unsigned COLS            = 32,
  parameter int unsigned LANES           = 2,
  parameter int unsigned PROJ_ADDR_WIDTH = 16,
  parameter int unsigned FEA_ADDR_WIDTH  = 8
) (
  input  logic [31:0]                             i_row,
  input  logic [31:0]                             i_beat,
  output logic [LANES-1:0][PROJ_ADDR_WIDTH-1:0]   o_proj_addrs,
  output logic [LANES-1:0][FEA_ADDR_WIDTH-1:0]    o_fea_addrs,
  output logic [LANES-1:0]                        o_lane_valid
);

  logic [31:0] w_col;

  // Lane k carries column beat*LANES+k; columns past the row end stay zero and invalid
  always_comb begin
    o_proj_addrs = '0;
    o_fea_addrs  = '0;
    o_lane_valid = '0;
    w_col        = '0;
    for (int k = 0; k < int'(LANES); k++) begin
      w_col = i_beat * LANES + 32'(k);
      if (w_col < COLS) begin
        o_lane_valid[k] = 1'b1;
        o_proj_addrs[k] = PROJ_ADDR_WIDTH'(i_row * COLS + w_col);
        o_fea_addrs[k]  = FEA_ADDR_WIDTH'(w_col);
      end
    end
  end

endmodule

// File: rtl/encoding_sequencer.sv
// Encode-frame sequencer: walks projection memory row by row, issuing LANES
// address pairs per beat and waiting for the MAC's row_ack between rows.
// Optional ENC_SEQ_PERF_EN adds saturating stall / ack-wait cycle counters.
module encoding_sequencer
  import enc_pkg::*;
#(
  parameter int unsigned DHV_SIZE        = 4000,
  parameter int unsigned DIV_SIZE        = 512,
  parameter int unsigned PROJ_OUT_WIDTH  = 16,
  parameter int unsigned LANES           = 2,
  parameter int unsigned PROJ_ADDR_WIDTH = 16,
  parameter int unsigned FEA_ADDR_WIDTH  = 8
) (
  input  logic                                   clk,
  input  logic                                   reset_in,
  input  logic                                   start,
  input  logic                                   data_ready,
  input  logic                                   row_ack,
  output logic [LANES-1:0][PROJ_ADDR_WIDTH-1:0]  proj_addrs,
  output logic [LANES-1:0][FEA_ADDR_WIDTH-1:0]   fea_addrs,
  output logic [LANES-1:0]                       lane_valid,
  output logic                                   beat_valid,
  output logic                                   row_last,
  output logic [PROJ_ADDR_WIDTH-1:0]             row_idx,
  output logic                                   busy,
  output logic                                   frame_done
`ifdef ENC_SEQ_PERF_EN
  ,
  output logic [31:0]                            stall_cycles,
  output logic [31:0]                            ack_wait_cycles
`endif
);

  localparam int unsigned ROWS  = calc_rows(DHV_SIZE, PROJ_OUT_WIDTH);
  localparam int unsigned COLS  = calc_cols(DIV_SIZE, PROJ_OUT_WIDTH);
  localparam int unsigned BEATS = calc_beats(COLS, LANES);

  enc_seq_state_t r_state, w_state_d;
  logic [31:0]    r_row, w_row_d;
  logic [31:0]    r_beat, w_beat_d;
  logic           w_issue_d;
  logic           w_busy_d;

  logic [LANES-1:0][PROJ_ADDR_WIDTH-1:0] w_proj;
  logic [LANES-1:0][FEA_ADDR_WIDTH-1:0]  w_fea;
  logic [LANES-1:0]                      w_valid;

  // Addresses are derived from the next (row, beat) so the registered outputs line up with state
  enc_lane_addr_gen #(
    .COLS            (COLS),
    .LANES           (LANES),
    .PROJ_ADDR_WIDTH (PROJ_ADDR_WIDTH),
    .FEA_ADDR_WIDTH  (FEA_ADDR_WIDTH)
  ) u_lane_addr_gen (
    .i_row        (w_row_d),
    .i_beat       (w_beat_d),
    .o_proj_addrs (w_proj),
    .o_fea_addrs  (w_fea),
    .o_lane_valid (w_valid)
  );

  // Next-state and counter update
  always_comb begin
    w_state_d = r_state;
    w_row_d   = r_row;
    w_beat_d  = r_beat;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_state_d = ISSUE;
          w_row_d   = '0;
          w_beat_d  = '0;
        end
      end
      ISSUE: begin
        if (data_ready) begin
          if (r_beat == BEATS - 1) w_state_d = WAIT_ACK;
          else                     w_beat_d  = r_beat + 32'd1;
        end
      end
      WAIT_ACK: begin
        if (row_ack) begin
          if (r_row == ROWS - 1) begin
            w_state_d = DONE;
          end else begin
            w_state_d = ISSUE;
            w_row_d   = r_row + 32'd1;
            w_beat_d  = '0;
          end
        end
      end
      DONE:    w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
    w_issue_d = (w_state_d == ISSUE);
    w_busy_d  = (w_state_d == ISSUE) || (w_state_d == WAIT_ACK);
  end

  // State and counter registers
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      r_state <= IDLE;
      r_row   <= '0;
      r_beat  <= '0;
    end else begin
      r_state <= w_state_d;
      r_row   <= w_row_d;
      r_beat  <= w_beat_d;
    end
  end

  // Registered outputs; addresses are zeroed whenever no beat is presented
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      proj_addrs <= '0;
      fea_addrs  <= '0;
      lane_valid <= '0;
      beat_valid <= 1'b0;
      row_last   <= 1'b0;
      row_idx    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      proj_addrs <= w_issue_d ? w_proj : '0;
      fea_addrs  <= w_issue_d ? w_fea : '0;
      lane_valid <= w_issue_d ? w_valid : '0;
      beat_valid <= w_issue_d && (|w_valid);
      row_last   <= w_issue_d && (w_beat_d == BEATS - 1);
      row_idx    <= w_busy_d ? PROJ_ADDR_WIDTH'(w_row_d) : '0;
      busy       <= w_busy_d;
      frame_done <= (w_state_d == DONE);
    end
  end

`ifdef ENC_SEQ_PERF_EN
  // Saturating performance counters, cleared when a frame is accepted
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      stall_cycles    <= '0;
      ack_wait_cycles <= '0;
    end else if (r_state == IDLE && start) begin
      stall_cycles    <= '0;
      ack_wait_cycles <= '0;
    end else begin
      if (r_state == ISSUE && !data_ready && stall_cycles != '1) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (r_state == WAIT_ACK && ack_wait_cycles != '1) begin
        ack_wait_cycles <= ack_wait_cycles + 32'd1;
      end
    end
  end
`endif

endmodule
